// File: rtl/led_tx_scheduler.sv
// Two-channel round-robin scheduler feeding the LED color transmitter.
// Each valid grant drives tx high for HOLD_CYC cycles, then a GAP_CYC guard.
module led_tx_scheduler #(
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 2
) (
  input  logic       p_clock,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] led0,
  input  logic       req1,
  input  logic [2:0] led1,
  output logic       ack0,
  output logic       ack1,
  output logic [2:0] led,
  output logic       tx,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_M1  =
    (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_last;

  logic       w_any;
  logic       w_win;
  logic [2:0] w_pat;
  logic       w_valid;

  // A grant is held off while an ack is still showing, so ack/err
  // can never pulse on two consecutive cycles after a reject.
  assign w_any   = (req0 | req1) & ~(ack0 | ack1);
  assign w_win   = (req0 & req1) ? ~r_last : req1;
  assign w_pat   = w_win ? led1 : led0;
  assign w_valid = (w_pat == 3'b111) | (w_pat == 3'b001) |
                   (w_pat == 3'b010) | (w_pat == 3'b100);
  assign busy    = (r_state != IDLE);

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_last  <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      tx      <= 1'b0;
      led     <= 3'b000;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last <= w_win;
            ack0   <= ~w_win;
            ack1   <= w_win;
            if (w_valid) begin
              led     <= w_pat;
              tx      <= 1'b1;
              r_cnt   <= HOLD_M1;
              r_state <= SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            tx <= 1'b0;
            if (GAP_CYC > 0) begin
              r_cnt   <= GAP_M1;
              r_state <= GAP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
          else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_tx_scheduler.sv
// Bench for led_tx_scheduler: two instances (8/2 and 4/0) against a
// timeline model of grants, symbol windows and round-robin order.
module tb_led_tx_scheduler;

  localparam int H0 = 8;
  localparam int G0 = 2;
  localparam int H1 = 4;
  localparam int G1 = 0;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst;

  logic       rq [2][2];
  logic [2:0] ld [2][2];
  logic       a0 [2];
  logic       a1 [2];
  logic       tx [2];
  logic       bz [2];
  logic       er [2];
  logic [2:0] led[2];

  int hold[2] = '{H0, H1};
  int gap [2] = '{G0, G1};

  longint     cyc;
  int         last[2];
  longint     g   [2];
  longint     free_at[2];
  logic [2:0] eled[2];
  logic       eack0[2];
  logic       eack1[2];
  logic       eerr[2];
  logic       etx [2];
  logic       ebusy[2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = clk_en & ~clk;

  led_tx_scheduler #(.HOLD_CYC(H0), .GAP_CYC(G0)) u_dut_a (
    .p_clock(clk), .rst(rst),
    .req0(rq[0][0]), .led0(ld[0][0]),
    .req1(rq[0][1]), .led1(ld[0][1]),
    .ack0(a0[0]), .ack1(a1[0]), .led(led[0]),
    .tx(tx[0]), .busy(bz[0]), .err(er[0])
  );

  led_tx_scheduler #(.HOLD_CYC(H1), .GAP_CYC(G1)) u_dut_b (
    .p_clock(clk), .rst(rst),
    .req0(rq[1][0]), .led0(ld[1][0]),
    .req1(rq[1][1]), .led1(ld[1][1]),
    .ack0(a0[1]), .ack1(a1[1]), .led(led[1]),
    .tx(tx[1]), .busy(bz[1]), .err(er[1])
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit is_valid(input logic [2:0] p);
    return p inside {3'b111, 3'b001, 3'b010, 3'b100};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      last[i]    = 1;
      g[i]       = -1000;
      free_at[i] = 0;
      eled[i]    = 3'b000;
      eack0[i]   = 1'b0;
      eack1[i]   = 1'b0;
      eerr[i]    = 1'b0;
      etx[i]     = 1'b0;
      ebusy[i]   = 1'b0;
    end
  endtask

  // One clock edge: decide grant from the request levels, then derive
  // outputs from where this edge falls relative to the last symbol.
  task automatic model_step();
    int w;
    logic [2:0] p;
    for (int i = 0; i < 2; i++) begin
      eack0[i] = 1'b0;
      eack1[i] = 1'b0;
      eerr[i]  = 1'b0;
      if (cyc >= free_at[i] && (rq[i][0] || rq[i][1])) begin
        if (rq[i][0] && rq[i][1]) w = (last[i] == 0) ? 1 : 0;
        else w = rq[i][1] ? 1 : 0;
        p = ld[i][w];
        last[i] = w;
        if (w == 1) eack1[i] = 1'b1;
        else eack0[i] = 1'b1;
        if (is_valid(p)) begin
          g[i]       = cyc;
          eled[i]    = p;
          free_at[i] = cyc + hold[i] + gap[i] + 1;
        end else begin
          eerr[i]    = 1'b1;
          free_at[i] = cyc + 2;
        end
      end
      etx[i]   = (cyc >= g[i]) && (cyc < g[i] + hold[i]);
      ebusy[i] = (cyc >= g[i]) && (cyc < g[i] + hold[i] + gap[i]);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack0[%0d]", i), 8'(a0[i]), 8'(eack0[i]));
      chk($sformatf("ack1[%0d]", i), 8'(a1[i]), 8'(eack1[i]));
      chk($sformatf("err[%0d]", i), 8'(er[i]), 8'(eerr[i]));
      chk($sformatf("tx[%0d]", i), 8'(tx[i]), 8'(etx[i]));
      chk($sformatf("busy[%0d]", i), 8'(bz[i]), 8'(ebusy[i]));
      chk($sformatf("led[%0d]", i), 8'(led[i]), 8'(eled[i]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_tx[%0d]", tag, i), 8'(tx[i]), 8'd0);
      chk($sformatf("%s_busy[%0d]", tag, i), 8'(bz[i]), 8'd0);
      chk($sformatf("%s_led[%0d]", tag, i), 8'(led[i]), 8'd0);
      chk($sformatf("%s_ack[%0d]", tag, i), 8'({a0[i], a1[i]}), 8'd0);
      chk($sformatf("%s_err[%0d]", tag, i), 8'(er[i]), 8'd0);
    end
  endtask

  function automatic logic [2:0] pick();
    case ($urandom_range(0, 5))
      0: return 3'b111;
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      4: return 3'($urandom_range(0, 7));
      default: return 3'b011;
    endcase
  endfunction

  // Requesters drop req in the cycle they see ack; mode 1 re-raises
  // fixed patterns at once (contention on a, back-to-back on b).
  task automatic drive(input int mode);
    logic ak;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        ak = (c == 0) ? eack0[i] : eack1[i];
        if (ak) begin
          rq[i][c] = 1'b0;
        end else if (mode == 1) begin
          rq[i][c] = (i == 0) || (c == 0);
          ld[i][c] = (i == 1) ? 3'b010 : ((c == 0) ? 3'b111 : 3'b100);
        end else if (!rq[i][c] && $urandom_range(0, 3) == 0) begin
          rq[i][c] = 1'b1;
          ld[i][c] = pick();
        end
      end
    end
  endtask

  task automatic run(input int n, input int mode);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      if (!rst) model_step();
      #1;
      if (!rst) check_all();
      drive(mode);
    end
  endtask

  task automatic mid_reset();
    int k = 0;
    while (!(etx[0] && (cyc - g[0] == 2)) && k < 60) begin
      run(1, 1);
      k++;
    end
    chk("reach_send3", 8'(k < 60), 8'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_reset_vals("async_rst");
    run(3, 1);
    rq[0][0] = 1'b1; ld[0][0] = 3'b111;
    rq[0][1] = 1'b1; ld[0][1] = 3'b100;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        rq[i][c] = 1'b0;
        ld[i][c] = 3'b000;
      end
    end
    model_reset();
    #3 check_reset_vals("por");
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    run(4, 2);
    run(60, 1);
    run(300, 0);
    mid_reset();
    run(60, 1);
    run(250, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
